hc595_driver: RTL and testbench

HC595_DRIVER -- requirements
Module: hc595_driver

---
 rtl/hc595_pkg.sv | 32 +++
 rtl/hc595_tick_gen.sv | 34 +++
 rtl/hc595_driver.sv | 91 +++++++++
 tb/tb_hc595_driver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hc595_pkg.sv
// Shared constants and step decoding for the 74HC595 serial driver.
package hc595_pkg;

   localparam int unsigned CLK_DIV_DEF  = 4;
   localparam int unsigned NUM_BITS_DEF = 16;

   // Steps in one frame: two per shifted bit, then latch-high and latch-low.
   function automatic int unsigned frame_steps(int unsigned nb);
      return 2 * nb + 2;
   endfunction

   localparam int unsigned FRAME_STEPS_DEF = frame_steps(NUM_BITS_DEF);

   typedef enum logic [1:0] {
      STEP_SHIFT_LOW,
      STEP_SHIFT_HIGH,
      STEP_LATCH,
      STEP_CLOSE
   } step_kind_t;

   // What a given step index does within a frame of nb bits.
   function automatic step_kind_t step_kind(int unsigned step, int unsigned nb);
      if (step < 2 * nb) begin
         return step[0] ? STEP_SHIFT_HIGH : STEP_SHIFT_LOW;
      end
      if (step == 2 * nb) begin
         return STEP_LATCH;
      end
      return STEP_CLOSE;
   endfunction

endpackage

// File: rtl/hc595_tick_gen.sv
// Clock divider: one-clock tick every CLK_DIV system clocks while enabled.
module hc595_tick_gen
   import hc595_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   // Divider counter 0..CLK_DIV-1, held at zero in reset or while disabled.
   always_ff @(posedge clk) begin
      if (!rst || !en) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Tick marks the last clock of each divider period.
   always_comb begin
      tick = (cnt == LAST);
   end

endmodule

// File: rtl/hc595_driver.sv
// Continuous-refresh serialiser for cascaded 74HC595 shift registers.
module hc595_driver
   import hc595_pkg::*;
#(
   parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
   parameter int unsigned NUM_BITS = NUM_BITS_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_BITS-1:0] data_in,
   input  logic                en,
   output logic                ds,
   output logic                sh_cp,
   output logic                st_cp
);

   localparam int unsigned STEPS = frame_steps(NUM_BITS);
   localparam int unsigned SW    = $clog2(STEPS);
   localparam int unsigned IW    = $clog2(NUM_BITS);
   localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

   logic                tick;
   logic [SW-1:0]       step, step_nxt;
   logic [NUM_BITS-1:0] shadow, shadow_nxt, src;
   logic [IW-1:0]       bit_idx;
   logic                ds_nxt, sh_nxt, st_nxt;

   hc595_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick)
   );

   // Step register, shadow word and output registers; reset beats enable beats tick.
   always_ff @(posedge clk) begin
      if (!rst) begin
         step   <= '0;
         shadow <= '0;
         ds     <= 1'b0;
         sh_cp  <= 1'b0;
         st_cp  <= 1'b0;
      end else if (!en) begin
         step   <= '0;
         ds     <= 1'b0;
         sh_cp  <= 1'b0;
         st_cp  <= 1'b0;
      end else begin
         step   <= step_nxt;
         shadow <= shadow_nxt;
         ds     <= ds_nxt;
         sh_cp  <= sh_nxt;
         st_cp  <= st_nxt;
      end
   end

   // Next step and output values; step 0 reads data_in directly since the shadow loads on that same edge.
   always_comb begin
      step_nxt   = step;
      shadow_nxt = shadow;
      ds_nxt     = ds;
      sh_nxt     = sh_cp;
      st_nxt     = st_cp;
      src        = (step == '0) ? data_in : shadow;
      bit_idx    = IW'(NUM_BITS - 1 - 32'(step >> 1));
      if (tick) begin
         step_nxt = (step == LAST_STEP) ? '0 : step + 1'b1;
         case (step_kind(32'(step), NUM_BITS))
            STEP_SHIFT_LOW: begin
               sh_nxt = 1'b0;
               ds_nxt = src[bit_idx];
               if (step == '0) begin
                  shadow_nxt = data_in;
               end
            end
            STEP_SHIFT_HIGH: begin
               sh_nxt = 1'b1;
            end
            STEP_LATCH: begin
               sh_nxt = 1'b0;
               st_nxt = 1'b1;
            end
            STEP_CLOSE: begin
               st_nxt = 1'b0;
               ds_nxt = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hc595_driver.sv
// Scoreboard bench for hc595_driver: frame-level reference model plus waveform checks.
module tb_hc595_driver;

   localparam int unsigned CLK_DIV  = 4;
   localparam int unsigned NUM_BITS = 16;
   localparam int unsigned FRAME    = 34 * CLK_DIV;
   localparam int unsigned LATCH_AT = CLK_DIV + 32 * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b0;
   logic [15:0] data_in = '0;
   logic        ds, sh_cp, st_cp;

   int unsigned errors = 0;
   int unsigned checks = 0;

   hc595_driver #(.CLK_DIV(CLK_DIV), .NUM_BITS(NUM_BITS)) dut (
      .clk     (clk),
      .rst     (rst),
      .data_in (data_in),
      .en      (en),
      .ds      (ds),
      .sh_cp   (sh_cp),
      .st_cp   (st_cp)
   );

   always #5 clk = ~clk;

   // Reference model: counts consecutive active edges; frame starts CLK_DIV edges in and repeats every FRAME.
   int unsigned run_len = 0;
   bit          act = 1'b0;
   logic [15:0] frame_word = '0;
   logic [15:0] exp_q[$];
   int unsigned frames_pushed = 0;

   always @(posedge clk) begin
      act = rst && en;
      if (!act) begin
         run_len = 0;
      end else begin
         run_len++;
         if (run_len % FRAME == CLK_DIV) frame_word = data_in;
         if (run_len % FRAME == LATCH_AT) begin
            exp_q.push_back(frame_word);
            frames_pushed++;
         end
      end
   end

   // Monitor: samples outputs on the falling edge, collects shifted bits, compares at each latch pulse.
   int unsigned t = 0, last_rise_t = 0, last_ds_t = 0;
   int unsigned sh_hi_len = 0, st_len = 0, bit_cnt = 0, frames_seen = 0;
   logic [15:0] bits = '0;
   logic        prev_sh = 1'b0, prev_st = 1'b0, prev_ds = 1'b0;
   bit          seen_rise = 1'b0;

   always @(negedge clk) begin
      bit          exp_st;
      logic [15:0] exp_w;
      t++;
      exp_st = act && (run_len % FRAME >= LATCH_AT);
      checks++;
      if (st_cp !== exp_st) begin
         errors++;
         $display("FAIL st_cp_timing t=%0d got=%b exp=%b", t, st_cp, exp_st);
      end
      if (!act) begin
         checks++;
         if ({ds, sh_cp, st_cp} !== 3'b000) begin
            errors++;
            $display("FAIL forced_zero t=%0d got ds/sh/st=%b exp=000", t, {ds, sh_cp, st_cp});
         end
         bit_cnt   = 0;
         seen_rise = 1'b0;
      end else begin
         if (sh_cp && !prev_sh) begin
            checks++;
            assert (t - last_ds_t >= CLK_DIV) else begin
               errors++;
               $display("FAIL ds_setup t=%0d got=%0d exp>=%0d", t, t - last_ds_t, CLK_DIV);
            end
            bits        = {bits[14:0], ds};
            bit_cnt++;
            last_rise_t = t;
            seen_rise   = 1'b1;
         end
         if (!sh_cp && prev_sh) begin
            checks++;
            assert (sh_hi_len == CLK_DIV) else begin
               errors++;
               $display("FAIL sh_high_width t=%0d got=%0d exp=%0d", t, sh_hi_len, CLK_DIV);
            end
         end
         if (ds !== prev_ds && seen_rise) begin
            checks++;
            assert (t - last_rise_t >= CLK_DIV) else begin
               errors++;
               $display("FAIL ds_hold t=%0d got=%0d exp>=%0d", t, t - last_rise_t, CLK_DIV);
            end
         end
         if (st_cp && !prev_st) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL frame_word t=%0d got=%h exp=none", t, bits);
            end else begin
               exp_w = exp_q.pop_front();
               if (bits !== exp_w || bit_cnt != 16) begin
                  errors++;
                  $display("FAIL frame_word t=%0d got=%h (%0d bits) exp=%h (16 bits)", t, bits, bit_cnt, exp_w);
               end
            end
            checks++;
            if (t - last_rise_t != CLK_DIV) begin
               errors++;
               $display("FAIL st_delay t=%0d got=%0d exp=%0d", t, t - last_rise_t, CLK_DIV);
            end
            frames_seen++;
            bit_cnt   = 0;
            seen_rise = 1'b0;
         end
         if (!st_cp && prev_st) begin
            checks++;
            if (st_len != CLK_DIV) begin
               errors++;
               $display("FAIL st_width t=%0d got=%0d exp=%0d", t, st_len, CLK_DIV);
            end
         end
      end
      sh_hi_len = sh_cp ? (prev_sh ? sh_hi_len + 1 : 1) : 0;
      st_len    = st_cp ? (prev_st ? st_len + 1 : 1) : 0;
      if (ds !== prev_ds) last_ds_t = t;
      prev_sh = sh_cp;
      prev_st = st_cp;
      prev_ds = ds;
   end

   // Advance until the model reaches a given position in the frame, bounded by two frames.
   task automatic wait_run(input int unsigned target);
      for (int unsigned i = 0; i < 2 * FRAME; i++) begin
         @(posedge clk);
         #1;
         if (act && run_len % FRAME == target) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_run got=timeout exp=position %0d", target);
   endtask

   task automatic cycles(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Stimulus: directed scenarios followed by randomized data and enable drops.
   initial begin
      rst = 1'b0;
      en  = 1'b1;
      data_in = 16'h0000;
      cycles(20);
      rst = 1'b1;
      cycles(2 * FRAME);

      data_in = 16'h1234;
      cycles(2 * FRAME);

      wait_run(CLK_DIV + 10 * CLK_DIV);
      data_in = 16'h5678;
      cycles(2 * FRAME);

      data_in = 16'h1234;
      wait_run(CLK_DIV + 20 * CLK_DIV);
      en = 1'b0;
      cycles(7);
      en = 1'b1;
      cycles(2 * FRAME);

      wait_run(LATCH_AT + 1);
      rst = 1'b0;
      cycles(3);
      rst = 1'b1;
      cycles(2 * FRAME);

      for (int i = 0; i < 14; i++) begin
         data_in = 16'($urandom);
         cycles($urandom_range(200, 1));
         if ($urandom_range(3, 0) == 0) begin
            en = 1'b0;
            cycles($urandom_range(10, 1));
            en = 1'b1;
         end
      end
      data_in = 16'($urandom);
      cycles(3 * FRAME);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0 || frames_seen != frames_pushed) begin
         errors++;
         $display("FAIL frame_count got=%0d seen exp=%0d pushed (%0d pending)", frames_seen, frames_pushed, exp_q.size());
      end
      checks++;
      if (frames_pushed < 10) begin
         errors++;
         $display("FAIL frames_completed got=%0d exp>=10", frames_pushed);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
